// File: rtl/logip_pkg.sv
// Shared definitions for the logic-analyzer IP blocks.
//   - state_e     : tx serializer FSM states
//   - BYTE_W      : width of one UART byte
//   - WORD_W_DEF  : default core transmit word width
//   - GRP_ENABLED : polarity of a group-enable bit (1 = group enabled)
package logip_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int   BYTE_W      = 8;
    localparam int   WORD_W_DEF  = 32;
    localparam logic GRP_ENABLED = 1'b1;

endpackage

// File: rtl/sump_tx_serializer.sv
// Word-to-byte serializer between the logic-analyzer core tx port and the
// UART byte transmitter. Accepts one word per strobe, emits its bytes LSB
// first, skipping bytes whose channel group is disabled.
//
// Ports:
//   clk_i         system clock
//   rst_in        asynchronous active-low reset
//   word_i        word from core
//   word_stb_i    one-cycle word strobe from core
//   word_rdy_o    ready to accept a word (state == IDLE)
//   grp_en_i      per-byte group enable, captured with the word
//   uart_rdy_i    UART idle and able to take a byte
//   tx_byte_o     byte to UART (registered, holds last sent byte)
//   tx_byte_stb_o one-cycle byte strobe to UART (registered)
//   ovf_o         sticky: word strobe seen while not ready
module sump_tx_serializer
    import logip_pkg::*;
#(
    parameter  int WORD_W = WORD_W_DEF,
    localparam int NBYTES = WORD_W / BYTE_W
) (
    input  logic              clk_i,
    input  logic              rst_in,
    input  logic [WORD_W-1:0] word_i,
    input  logic              word_stb_i,
    output logic              word_rdy_o,
    input  logic [NBYTES-1:0] grp_en_i,
    input  logic              uart_rdy_i,
    output logic [BYTE_W-1:0] tx_byte_o,
    output logic              tx_byte_stb_o,
    output logic              ovf_o
);

    // idx must reach NBYTES (the "done" value), byte select only needs NBYTES-1.
    localparam int IDX_W  = $clog2(NBYTES + 1);
    localparam int BSEL_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES);

    state_e              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [WORD_W-1:0]   data_q;
    logic [NBYTES-1:0]   mask_q;
    logic [BYTE_W-1:0]   tx_byte_q;
    logic                tx_byte_stb_q;
    logic                ovf_q;
    logic [BSEL_W-1:0]   bsel;

    // Only used while idx_q < NBYTES, so truncation never aliases.
    assign bsel = idx_q[BSEL_W-1:0];

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            data_q        <= '0;
            mask_q        <= '0;
            tx_byte_q     <= '0;
            tx_byte_stb_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            // A strobe outside IDLE is dropped; only the error flag records it.
            if (word_stb_i && (state_q != ST_IDLE)) ovf_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    tx_byte_stb_q <= 1'b0;
                    if (word_stb_i) begin
                        data_q  <= word_i;
                        mask_q  <= grp_en_i;
                        idx_q   <= '0;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    tx_byte_stb_q <= 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_IDLE;
                    end else if (mask_q[bsel] != GRP_ENABLED) begin
                        idx_q <= idx_q + IDX_W'(1);
                    end else if (uart_rdy_i) begin
                        tx_byte_q     <= data_q[BYTE_W*bsel +: BYTE_W];
                        tx_byte_stb_q <= 1'b1;
                        state_q       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Gives the UART a cycle to drop uart_rdy_i before the next byte.
                    tx_byte_stb_q <= 1'b0;
                    idx_q         <= idx_q + IDX_W'(1);
                    state_q       <= ST_SEND;
                end
                default: begin
                    tx_byte_stb_q <= 1'b0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign word_rdy_o    = (state_q == ST_IDLE);
    assign tx_byte_o     = tx_byte_q;
    assign tx_byte_stb_o = tx_byte_stb_q;
    assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_sump_tx_serializer.sv
// Directed bench for sump_tx_serializer.
module tb_sump_tx_serializer;

    logic        clk_i = 1'b0;
    logic        rst_in;
    logic [31:0] word_i;
    logic        word_stb_i;
    logic        word_rdy_o;
    logic [3:0]  grp_en_i;
    logic        uart_rdy_i;
    logic [7:0]  tx_byte_o;
    logic        tx_byte_stb_o;
    logic        ovf_o;

    sump_tx_serializer #(.WORD_W(32)) dut (
        .clk_i         (clk_i),
        .rst_in        (rst_in),
        .word_i        (word_i),
        .word_stb_i    (word_stb_i),
        .word_rdy_o    (word_rdy_o),
        .grp_en_i      (grp_en_i),
        .uart_rdy_i    (uart_rdy_i),
        .tx_byte_o     (tx_byte_o),
        .tx_byte_stb_o (tx_byte_stb_o),
        .ovf_o         (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int dbl_stb = 0;
    logic prev_stb = 1'b0;
    logic [7:0] bq[$];
    int         cq[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Byte log, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (tx_byte_stb_o) begin
            bq.push_back(tx_byte_o);
            cq.push_back(cyc);
        end
        if (tx_byte_stb_o && prev_stb) dbl_stb++;
        prev_stb = tx_byte_stb_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Strobe one word; returns aligned at #1 after the accept edge.
    task automatic accept_word(input logic [31:0] w, input logic [3:0] m);
        word_i     = w;
        grp_en_i   = m;
        word_stb_i = 1'b1;
        tick();
        word_stb_i = 1'b0;
        grp_en_i   = ~m; // later changes must not affect the captured mask
    endtask

    // Edges counted until word_rdy_o rises, bounded.
    task automatic wait_idle(input string tag, output int n);
        n = 0;
        while (!word_rdy_o && n < 60) begin
            tick();
            n++;
        end
        if (!word_rdy_o) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // exp holds expected bytes packed LSB-first; consecutive strobes 2 cycles apart.
    task automatic check_bytes(input string tag, input int n, input logic [31:0] exp);
        chk({tag, "_count"}, bq.size(), n);
        for (int k = 0; k < n && k < bq.size(); k++) begin
            chk($sformatf("%s_byte%0d", tag, k), {24'd0, bq[k]}, {24'd0, exp[8*k +: 8]});
            if (k > 0) chk($sformatf("%s_gap%0d", tag, k), cq[k] - cq[k-1], 32'd2);
        end
    endtask

    initial begin
        int n;
        int t_raise;
        rst_in     = 1'b0;
        word_i     = '0;
        word_stb_i = 1'b0;
        grp_en_i   = '0;
        uart_rdy_i = 1'b1;
        #12;
        chk("rst_rdy",  word_rdy_o,    1);
        chk("rst_stb",  tx_byte_stb_o, 0);
        chk("rst_byte", tx_byte_o,     0);
        chk("rst_ovf",  ovf_o,         0);
        tick();
        rst_in = 1'b1;
        tick();

        // Full send
        bq.delete(); cq.delete();
        accept_word(32'hA1B2C3D4, 4'hF);
        chk("full_busy", word_rdy_o, 0);
        wait_idle("full", n);
        chk("full_cycles", n, 9);
        check_bytes("full", 4, 32'hA1B2C3D4);
        chk("full_ovf", ovf_o, 0);
        chk("full_hold_byte", tx_byte_o, 8'hA1);

        // Masked 0101
        tick();
        bq.delete(); cq.delete();
        accept_word(32'h11223344, 4'b0101);
        wait_idle("mask", n);
        chk("mask_cycles", n, 7);
        chk("mask_count", bq.size(), 2);
        if (bq.size() == 2) begin
            chk("mask_b0", bq[0], 8'h44);
            chk("mask_b1", bq[1], 8'h22);
        end

        // Zero mask
        tick();
        bq.delete(); cq.delete();
        accept_word(32'hFFFFFFFF, 4'h0);
        wait_idle("zero", n);
        chk("zero_cycles", n, 5);
        chk("zero_count", bq.size(), 0);

        // Backpressure
        tick();
        bq.delete(); cq.delete();
        uart_rdy_i = 1'b0;
        accept_word(32'hCAFEF00D, 4'hF);
        repeat (10) tick();
        chk("bp_nostb", bq.size(), 0);
        chk("bp_busy", word_rdy_o, 0);
        t_raise    = cyc;
        uart_rdy_i = 1'b1;
        wait_idle("bp", n);
        check_bytes("bp", 4, 32'hCAFEF00D);
        if (cq.size() > 0) chk("bp_first_lat", cq[0] - t_raise, 1);

        // Overflow
        tick();
        bq.delete(); cq.delete();
        accept_word(32'h01020304, 4'hF);
        tick(); tick();
        word_i     = 32'hDEADBEEF;
        grp_en_i   = 4'hF;
        word_stb_i = 1'b1;
        tick();
        word_stb_i = 1'b0;
        chk("ovf_set", ovf_o, 1);
        wait_idle("ovf", n);
        chk("ovf_cycles", n, 6);
        check_bytes("ovf", 4, 32'h01020304);
        tick(); tick();
        chk("ovf_sticky", ovf_o, 1);
        chk("ovf_no_second", word_rdy_o, 1);

        // Reset mid-transfer after the second byte strobe
        bq.delete(); cq.delete();
        accept_word(32'h55667788, 4'hF);
        n = 0;
        while (bq.size() < 2 && n < 40) begin
            @(negedge clk_i); #1;
            n++;
        end
        chk("mid_reach2", bq.size(), 2);
        rst_in = 1'b0;
        #1;
        chk("mid_rdy",  word_rdy_o,    1);
        chk("mid_stb",  tx_byte_stb_o, 0);
        chk("mid_byte", tx_byte_o,     0);
        chk("mid_ovf",  ovf_o,         0);
        tick(); tick();
        rst_in = 1'b1;
        repeat (8) tick();
        chk("mid_quiet", bq.size(), 2);
        chk("mid_idle", word_rdy_o, 1);
        bq.delete(); cq.delete();
        accept_word(32'h99AABBCC, 4'hF);
        wait_idle("post", n);
        chk("post_cycles", n, 9);
        check_bytes("post", 4, 32'h99AABBCC);

        chk("no_double_stb", dbl_stb, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
